// File: rtl/ftdi_245fifo_device.sv
// FTDI 245-style synchronous FIFO device model: host-side valid/ready FIFOs bridged to 245 pins.
// Optional protocol checker is enabled by defining FTDI_DEV_PROTOCOL_CHECK_EN.
module ftdi_245fifo_device #(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned RX_ASIZE = 4,
  parameter int unsigned TX_ASIZE = 4
) (
  input  logic                 usb_clk,
  input  logic                 rst,
  // Host side, host -> FPGA direction
  input  logic                 h_tx_valid,
  output logic                 h_tx_ready,
  input  logic [DSIZE-1:0]     h_tx_data,
  // Host side, FPGA -> host direction
  output logic                 h_rx_valid,
  input  logic                 h_rx_ready,
  output logic [DSIZE-1:0]     h_rx_data,
  // 245 pin side
  output logic                 usb_rxf,
  output logic                 usb_txe,
  input  logic                 usb_rd,
  input  logic                 usb_wr,
  input  logic                 usb_oe,
  inout  wire  [DSIZE-1:0]     usb_data,
  inout  wire  [DSIZE/8-1:0]   usb_be,
  output logic                 proto_err
);

  localparam int unsigned RX_DEPTH = 2 ** RX_ASIZE;
  localparam int unsigned TX_DEPTH = 2 ** TX_ASIZE;
  localparam logic [RX_ASIZE:0] RX_FULL = {1'b1, {RX_ASIZE{1'b0}}};
  localparam logic [TX_ASIZE:0] TX_FULL = {1'b1, {TX_ASIZE{1'b0}}};

  // ---------------------------------------------------------------------------
  // RX FIFO: host pushes, pins pop
  // ---------------------------------------------------------------------------
  logic [DSIZE-1:0]    r_rx_mem [RX_DEPTH];
  logic [RX_ASIZE-1:0] r_rx_wptr;
  logic [RX_ASIZE-1:0] r_rx_rptr;
  logic [RX_ASIZE:0]   r_rx_cnt;
  logic [RX_ASIZE:0]   w_rx_cnt_d;
  logic                w_rx_full;
  logic                w_rx_empty;
  logic                w_rx_push;
  logic                w_rx_pop;
  logic                r_oe;
  logic                w_bus_drv;

  assign w_rx_full  = (r_rx_cnt == RX_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_push  = h_tx_valid & ~w_rx_full;
  assign w_rx_pop   = ~usb_rd & ~usb_oe & ~w_rx_empty;

  assign h_tx_ready = ~w_rx_full;
  assign usb_rxf    = w_rx_empty;

  always_comb begin
    w_rx_cnt_d = r_rx_cnt;
    unique case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_cnt_d = r_rx_cnt + (RX_ASIZE+1)'(1);
      2'b01:   w_rx_cnt_d = r_rx_cnt - (RX_ASIZE+1)'(1);
      default: w_rx_cnt_d = r_rx_cnt;
    endcase
  end

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_ASIZE'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_ASIZE'(1);
      r_rx_cnt <= w_rx_cnt_d;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= h_tx_data;
  end

  // One cycle of OE low before the bus is driven gives the external controller a turnaround slot.
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) r_oe <= 1'b0;
    else     r_oe <= ~usb_oe;
  end

  assign w_bus_drv = r_oe & ~usb_oe;
  assign usb_data  = w_bus_drv ? r_rx_mem[r_rx_rptr] : {DSIZE{1'bz}};
  assign usb_be    = w_bus_drv ? {(DSIZE/8){1'b1}} : {(DSIZE/8){1'bz}};

  // ---------------------------------------------------------------------------
  // TX FIFO: pins push, host pops
  // ---------------------------------------------------------------------------
  logic [DSIZE-1:0]    r_tx_mem [TX_DEPTH];
  logic [TX_ASIZE-1:0] r_tx_wptr;
  logic [TX_ASIZE-1:0] r_tx_rptr;
  logic [TX_ASIZE:0]   r_tx_cnt;
  logic [TX_ASIZE:0]   w_tx_cnt_d;
  logic                w_tx_full;
  logic                w_tx_empty;
  logic                w_tx_push;
  logic                w_tx_pop;

  assign w_tx_full  = (r_tx_cnt == TX_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_push  = ~usb_wr & ~w_tx_full;
  assign w_tx_pop   = h_rx_ready & ~w_tx_empty;

  assign usb_txe    = w_tx_full;
  assign h_rx_valid = ~w_tx_empty;
  assign h_rx_data  = r_tx_mem[r_tx_rptr];

  always_comb begin
    w_tx_cnt_d = r_tx_cnt;
    unique case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_cnt_d = r_tx_cnt + (TX_ASIZE+1)'(1);
      2'b01:   w_tx_cnt_d = r_tx_cnt - (TX_ASIZE+1)'(1);
      default: w_tx_cnt_d = r_tx_cnt;
    endcase
  end

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_ASIZE'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_ASIZE'(1);
      r_tx_cnt <= w_tx_cnt_d;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= usb_data;
  end

  // ---------------------------------------------------------------------------
  // Protocol checker
  // ---------------------------------------------------------------------------
`ifdef FTDI_DEV_PROTOCOL_CHECK_EN
  logic r_proto_err;
  logic w_proto_viol;

  assign w_proto_viol = (~usb_rd & usb_oe)
                      | (~usb_wr & w_tx_full)
                      | (~usb_wr & ~usb_oe)
                      | (~usb_rd & ~r_oe);

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst)               r_proto_err <= 1'b0;
    else if (w_proto_viol) r_proto_err <= 1'b1;
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_ftdi_245fifo_device.sv
// Randomized bench for ftdi_245fifo_device against a queue-based reference model.
// Honours FTDI_DEV_PROTOCOL_CHECK_EN when predicting proto_err.
module tb_ftdi_245fifo_device;

  localparam int DEPTH = 16;
`ifdef FTDI_DEV_PROTOCOL_CHECK_EN
  localparam bit PROTO_EN = 1'b1;
`else
  localparam bit PROTO_EN = 1'b0;
`endif

  logic       usb_clk = 1'b0;
  logic       rst;
  logic       h_tx_valid, h_tx_ready, h_rx_valid, h_rx_ready;
  logic [7:0] h_tx_data, h_rx_data;
  logic       usb_rxf, usb_txe, usb_rd, usb_wr, usb_oe, proto_err;
  wire  [7:0] usb_data;
  wire  [0:0] usb_be;
  logic       tb_drv;
  logic [7:0] tb_wdata;

  // Bench acts as the FPGA-side controller; it owns the bus only while writing.
  assign usb_data = tb_drv ? tb_wdata : 8'hzz;
  assign usb_be   = tb_drv ? 1'b0 : 1'bz;

  always #5 usb_clk = ~usb_clk;

  ftdi_245fifo_device #(.DSIZE(8), .RX_ASIZE(4), .TX_ASIZE(4)) dut (
    .usb_clk   (usb_clk),
    .rst       (rst),
    .h_tx_valid(h_tx_valid),
    .h_tx_ready(h_tx_ready),
    .h_tx_data (h_tx_data),
    .h_rx_valid(h_rx_valid),
    .h_rx_ready(h_rx_ready),
    .h_rx_data (h_rx_data),
    .usb_rxf   (usb_rxf),
    .usb_txe   (usb_txe),
    .usb_rd    (usb_rd),
    .usb_wr    (usb_wr),
    .usb_oe    (usb_oe),
    .usb_data  (usb_data),
    .usb_be    (usb_be),
    .proto_err (proto_err)
  );

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         m_oe;
  bit         m_err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic step(input bit hv, input logic [7:0] hd, input bit hr,
                      input bit oe_n, input bit rd_n, input bit wr_n, input logic [7:0] wd,
                      output bit popped, output logic [7:0] pdata,
                      output bit got, output logic [7:0] gdata);
    int rxs, txs;
    logic [7:0] seen, head;
    h_tx_valid = hv; h_tx_data = hd; h_rx_ready = hr;
    usb_oe = oe_n; usb_rd = rd_n; usb_wr = wr_n;
    tb_drv = !wr_n; tb_wdata = wd;
    #1;
    rxs = rx_q.size();
    txs = tx_q.size();
    check("h_tx_ready", h_tx_ready, rxs < DEPTH);
    check("usb_rxf", usb_rxf, rxs == 0);
    check("usb_txe", usb_txe, txs == DEPTH);
    check("h_rx_valid", h_rx_valid, txs != 0);
    if (txs != 0) check("h_rx_data", h_rx_data, tx_q[0]);
    check("proto_err", proto_err, m_err);
    if (m_oe && !oe_n) begin
      check("usb_be_dut", usb_be, 1);
      if (rxs != 0) check("usb_data_dut", usb_data, rx_q[0]);
    end else if (!wr_n) begin
      check("usb_be_tb", usb_be, 0);
      check("usb_data_tb", usb_data, wd);
    end
    seen = usb_data;
    head = h_rx_data;
    @(posedge usb_clk);
    popped = !rd_n && !oe_n && rxs != 0;
    pdata  = seen;
    got    = hr && txs != 0;
    gdata  = head;
    if (popped) void'(rx_q.pop_front());
    if (hv && rxs < DEPTH) rx_q.push_back(hd);
    if (got) void'(tx_q.pop_front());
    if (!wr_n && txs < DEPTH) tx_q.push_back(wd);
    if (PROTO_EN)
      m_err = m_err || (!rd_n && oe_n) || (!wr_n && txs == DEPTH) ||
              (!wr_n && !oe_n) || (!rd_n && !m_oe);
    m_oe = !oe_n;
    @(negedge usb_clk);
  endtask

  // Asserts reset off-edge and checks outputs respond before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_rxf", usb_rxf, 1);
    check("rst_txe", usb_txe, 0);
    check("rst_tx_ready", h_tx_ready, 1);
    check("rst_rx_valid", h_rx_valid, 0);
    check("rst_proto", proto_err, 0);
    rx_q.delete(); tx_q.delete(); m_oe = 0; m_err = 0;
    @(negedge usb_clk);
    @(negedge usb_clk);
    rst = 1'b0;
  endtask

  initial begin
    bit         p, g;
    logic [7:0] pd, gd;
    logic [7:0] exp_q[$];
    logic [7:0] src[1000];
    logic [7:0] fbuf[$];
    int         sent, recv;

    rst = 1'b1; h_tx_valid = 0; h_tx_data = 0; h_rx_ready = 0;
    usb_oe = 1; usb_rd = 1; usb_wr = 1; tb_drv = 0; tb_wdata = 0;
    m_oe = 0; m_err = 0;
    repeat (2) @(negedge usb_clk);
    do_reset();

    // Read strobe with OE high is a protocol violation
    step(0, 0, 0, 1, 0, 1, 0, p, pd, g, gd);
    repeat (3) step(0, 0, 0, 1, 1, 1, 0, p, pd, g, gd);
    check("proto_held", proto_err, PROTO_EN);
    do_reset();

    // Three host words read back over the pins after one OE turnaround cycle
    step(1, 8'h11, 0, 1, 1, 1, 0, p, pd, g, gd);
    step(1, 8'h22, 0, 1, 1, 1, 0, p, pd, g, gd);
    step(1, 8'h33, 0, 1, 1, 1, 0, p, pd, g, gd);
    step(0, 0, 0, 0, 1, 1, 0, p, pd, g, gd);
    step(0, 0, 0, 0, 0, 1, 0, p, pd, g, gd); check("rd0", pd, 8'h11); check("rd0_pop", p, 1);
    step(0, 0, 0, 0, 0, 1, 0, p, pd, g, gd); check("rd1", pd, 8'h22);
    step(0, 0, 0, 0, 0, 1, 0, p, pd, g, gd); check("rd2", pd, 8'h33);
    #1 check("rxf_after_three", usb_rxf, 1);
    step(0, 0, 0, 1, 1, 1, 0, p, pd, g, gd);

    // Fill TX to full, overflow write dropped, host drains in order
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 0, 8'(i), p, pd, g, gd);
    #1 check("txe_full", usb_txe, 1);
    step(0, 0, 0, 1, 1, 0, 8'hAA, p, pd, g, gd);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 1, 1, 1, 0, p, pd, g, gd);
      check("tx_drain", gd, 8'(i));
    end
    #1 check("tx_empty", h_rx_valid, 0);
    do_reset();

    // Concurrent push and pop at occupancy 8
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(8'h40 + i), 0, 1, 1, 1, 0, p, pd, g, gd);
      exp_q.push_back(8'(8'h40 + i));
    end
    step(0, 0, 0, 0, 1, 1, 0, p, pd, g, gd);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      step(1, d, 0, 0, 0, 1, 0, p, pd, g, gd);
      exp_q.push_back(d);
      check("steady_data", pd, exp_q.pop_front());
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, p, pd, g, gd);
      check("steady_drain", pd, exp_q.pop_front());
    end
    step(0, 0, 0, 1, 1, 1, 0, p, pd, g, gd);

    // Reset while RX holds five words and a read is in progress
    for (int i = 0; i < 5; i++) step(1, 8'(i + 1), 0, 1, 1, 1, 0, p, pd, g, gd);
    step(0, 0, 0, 0, 1, 1, 0, p, pd, g, gd);
    usb_oe = 0; usb_rd = 0;
    do_reset();
    step(0, 0, 0, 1, 1, 1, 0, p, pd, g, gd);
    step(1, 8'h5A, 0, 1, 1, 1, 0, p, pd, g, gd);
    step(0, 0, 0, 0, 1, 1, 0, p, pd, g, gd);
    step(0, 0, 0, 0, 0, 1, 0, p, pd, g, gd); check("post_rst_word", pd, 8'h5A);
    step(0, 0, 0, 1, 1, 1, 0, p, pd, g, gd);

    // Unconstrained random strobes (bus contention avoided: no write with OE low)
    for (int i = 0; i < 1500; i++) begin
      bit oe_n, rd_n, wr_n;
      oe_n = 1'($urandom); rd_n = 1'($urandom); wr_n = 1'($urandom);
      if (!wr_n) oe_n = 1;
      step(1'($urandom), 8'($urandom), 1'($urandom), oe_n, rd_n, wr_n, 8'($urandom),
           p, pd, g, gd);
    end
    step(0, 0, 0, 1, 1, 1, 0, p, pd, g, gd);
    do_reset();

    // Loopback through a well-behaved FPGA-side controller
    foreach (src[i]) src[i] = 8'($urandom);
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      bit hv, hr, acc, oe_n, rd_n, wr_n, wrote;
      logic [7:0] wd;
      hv = sent < 1000 && $urandom_range(0, 3) != 0;
      hr = $urandom_range(0, 3) != 0;
      acc = hv && rx_q.size() < DEPTH;
      oe_n = 1; rd_n = 1; wr_n = 1; wd = 0; wrote = 0;
      if (rx_q.size() != 0 && fbuf.size() < 4) begin
        oe_n = 0;
        rd_n = !m_oe;
      end else if (fbuf.size() != 0 && tx_q.size() < DEPTH) begin
        wr_n = 0; wd = fbuf[0]; wrote = 1;
      end
      step(hv, src[sent % 1000], hr, oe_n, rd_n, wr_n, wd, p, pd, g, gd);
      if (acc) sent++;
      if (wrote) void'(fbuf.pop_front());
      if (p) fbuf.push_back(pd);
      if (g) begin
        if (recv < 1000) check("loop_data", gd, src[recv]);
        recv++;
      end
    end
    check("loop_count", recv, 1000);
    check("loop_proto", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
